// File: rtl/dcf77_pkg.sv
// Shared definitions for the DCF77 transmitter: the frame bit map, the time record
// the host loads, and the function that turns a time record into a minute frame.
package dcf77_pkg;

    localparam int FRAME_BITS   = 59;
    localparam int BIT_ZONE_LSB = 17;
    localparam int BIT_START    = 20;
    localparam int BIT_MIN_LSB  = 21;
    localparam int BIT_P1       = 28;
    localparam int BIT_HOUR_LSB = 29;
    localparam int BIT_P2       = 35;
    localparam int BIT_DAY_LSB  = 36;
    localparam int BIT_WDAY_LSB = 42;
    localparam int BIT_MON_LSB  = 45;
    localparam int BIT_YEAR_LSB = 50;
    localparam int BIT_P3       = 58;

    typedef struct packed {
        logic [7:0] year;
        logic [4:0] month;
        logic [2:0] week_day;
        logic [5:0] day;
        logic [5:0] hour;
        logic [6:0] minute;
        logic [1:0] zone;
    } dcf77_time_t;

    typedef logic [FRAME_BITS-1:0] dcf77_frame_t;

    // Fields go out LSB first; parities are even over the field plus the parity bit.
    function automatic dcf77_frame_t encode_frame(input dcf77_time_t t);
        dcf77_frame_t f;
        f = '0;
        f[BIT_ZONE_LSB +: 2] = t.zone;
        f[BIT_START]         = 1'b1;
        f[BIT_MIN_LSB +: 7]  = t.minute;
        f[BIT_P1]            = ^t.minute;
        f[BIT_HOUR_LSB +: 6] = t.hour;
        f[BIT_P2]            = ^t.hour;
        f[BIT_DAY_LSB +: 6]  = t.day;
        f[BIT_WDAY_LSB +: 3] = t.week_day;
        f[BIT_MON_LSB +: 5]  = t.month;
        f[BIT_YEAR_LSB +: 8] = t.year;
        f[BIT_P3]            = ^{t.year, t.month, t.week_day, t.day};
        return f;
    endfunction

endpackage

// File: rtl/dcf77_tick.sv
// 10 ms enable generator: free-running divider that raises en_tick for one clk
// at its terminal count.
module dcf77_tick #(
    parameter int CLKS_PER_TICK = 240000
) (
    input  logic clk,
    input  logic rst,
    output logic en_tick
);

    localparam int W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [W-1:0] CNT_LAST = W'(CLKS_PER_TICK - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign en_tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (en_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dcf77_tx.sv
// DCF77 minute-frame transmitter: latches host time into a shadow register,
// encodes it at each minute boundary and emits 100/200 ms pulses per second.
module dcf77_tx
    import dcf77_pkg::*;
#(
    parameter int CLKS_PER_TICK = 240000,
    parameter int TICKS_PER_SEC = 100,
    parameter int TICKS_ZERO    = 10,
    parameter int TICKS_ONE     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [6:0] minute,
    input  logic [5:0] hour,
    input  logic [5:0] day,
    input  logic [2:0] week_day,
    input  logic [4:0] month,
    input  logic [7:0] year,
    input  logic [1:0] zone,
    output logic       tx,
    output logic [5:0] second,
    output logic       minute_strb,
    output logic       stale
);

    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] LEN_ZERO  = TW'(TICKS_ZERO);
    localparam logic [TW-1:0] LEN_ONE   = TW'(TICKS_ONE);
    localparam logic [5:0]    SEC_LAST  = 6'd59;

    logic          en_tick;
    logic          transfer;
    logic          accept;
    logic          bit_now;
    logic [TW-1:0] pulse_len;
    logic [59:0]   frame_ext;
    dcf77_time_t   load_time;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [5:0]    second_q, second_d;
    dcf77_frame_t  frame_q, frame_d;
    dcf77_time_t   shadow_q, shadow_d;
    logic          shadow_new_q, shadow_new_d;
    logic          stale_q, stale_d;
    logic          tx_q, tx_d;
    logic          strb_q, strb_d;

    dcf77_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_tick(en_tick)
    );

    assign load_time = {year, month, week_day, day, hour, minute, zone};

    // The last tick of second 59 is the only cycle the shadow is being read.
    assign transfer   = en_tick && (tick_cnt_q == TICK_LAST) && (second_q == SEC_LAST);
    assign load_ready = !transfer;
    assign accept     = load_valid && load_ready;

    // Second 59 has no frame bit; the padded zero keeps the index in range.
    assign frame_ext  = {1'b0, frame_q};
    assign bit_now    = frame_ext[second_q];
    assign pulse_len  = bit_now ? LEN_ONE : LEN_ZERO;

    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        second_d     = second_q;
        frame_d      = frame_q;
        shadow_d     = shadow_q;
        shadow_new_d = shadow_new_q;
        stale_d      = stale_q;
        tx_d         = (second_q != SEC_LAST) && (tick_cnt_q < pulse_len);
        strb_d       = transfer;

        if (en_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                second_d   = (second_q == SEC_LAST) ? 6'd0 : second_q + 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end

        if (transfer) begin
            frame_d      = encode_frame(shadow_q);
            stale_d      = !shadow_new_q;
            shadow_new_d = 1'b0;
        end

        if (accept) begin
            shadow_d     = load_time;
            shadow_new_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            second_q     <= SEC_LAST;
            frame_q      <= '0;
            shadow_q     <= '0;
            shadow_new_q <= 1'b0;
            stale_q      <= 1'b1;
            tx_q         <= 1'b0;
            strb_q       <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            second_q     <= second_d;
            frame_q      <= frame_d;
            shadow_q     <= shadow_d;
            shadow_new_q <= shadow_new_d;
            stale_q      <= stale_d;
            tx_q         <= tx_d;
            strb_q       <= strb_d;
        end
    end

    assign tx          = tx_q;
    assign second      = second_q;
    assign minute_strb = strb_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_dcf77_tx.sv
// Bench for dcf77_tx: decodes the pulse line tick by tick and compares each second's
// pulse length against a time-code model built directly from the DCF77 bit map.
module tb_dcf77_tx;

    localparam int TB_CLKS = 4;
    localparam int TB_TPS  = 100;

    typedef struct {
        int minute;
        int hour;
        int day;
        int week_day;
        int month;
        int year;
        int zone;
    } tb_time_t;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [2:0] week_day;
    logic [4:0] month;
    logic [7:0] year;
    logic [1:0] zone;
    logic       tx;
    logic [5:0] second;
    logic       minute_strb;
    logic       stale;

    int n_vec;
    int n_err;
    int obs_arr[60];

    dcf77_tx #(
        .CLKS_PER_TICK(TB_CLKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .minute     (minute),
        .hour       (hour),
        .day        (day),
        .week_day   (week_day),
        .month      (month),
        .year       (year),
        .zone       (zone),
        .tx         (tx),
        .second     (second),
        .minute_strb(minute_strb),
        .stale      (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int ones(input int v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += (v >> i) & 1;
        return c;
    endfunction

    function automatic int model_bit(input tb_time_t tm, input int s);
        if (s == 17) return tm.zone & 1;
        if (s == 18) return (tm.zone >> 1) & 1;
        if (s == 20) return 1;
        if (s >= 21 && s <= 27) return (tm.minute >> (s - 21)) & 1;
        if (s == 28) return ones(tm.minute) % 2;
        if (s >= 29 && s <= 34) return (tm.hour >> (s - 29)) & 1;
        if (s == 35) return ones(tm.hour) % 2;
        if (s >= 36 && s <= 41) return (tm.day >> (s - 36)) & 1;
        if (s >= 42 && s <= 44) return (tm.week_day >> (s - 42)) & 1;
        if (s >= 45 && s <= 49) return (tm.month >> (s - 45)) & 1;
        if (s >= 50 && s <= 57) return (tm.year >> (s - 50)) & 1;
        if (s == 58) return (ones(tm.day) + ones(tm.week_day) + ones(tm.month) + ones(tm.year)) % 2;
        return 0;
    endfunction

    function automatic int model_pulse(input tb_time_t tm, input int s);
        if (s == 59) return 0;
        return (model_bit(tm, s) != 0) ? 20 : 10;
    endfunction

    function automatic tb_time_t rand_time();
        tb_time_t t;
        t.minute   = int'($urandom & 32'h7f);
        t.hour     = int'($urandom & 32'h3f);
        t.day      = int'($urandom & 32'h3f);
        t.week_day = int'($urandom & 32'h7);
        t.month    = int'($urandom & 32'h1f);
        t.year     = int'($urandom & 32'hff);
        t.zone     = int'($urandom & 32'h3);
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_time(input tb_time_t tm);
        minute   = 7'(tm.minute);
        hour     = 6'(tm.hour);
        day      = 6'(tm.day);
        week_day = 3'(tm.week_day);
        month    = 5'(tm.month);
        year     = 8'(tm.year);
        zone     = 2'(tm.zone);
    endtask

    task automatic wait_strb();
        int w;
        w = 0;
        while (minute_strb !== 1'b1 && w < 30000) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Decode one frame from its minute_strb onward; returns at the sample point
    // of the last decoded tick.
    task automatic run_frame(input tb_time_t tm, input logic exp_stale, input int n_secs);
        logic [7:0] exp_q[$];
        int obs_len;
        logic hole;
        logic [7:0] exp_len;
        for (int s = 0; s < 60; s++) begin
            exp_q.push_back(8'(model_pulse(tm, s)));
            obs_arr[s] = -1;
        end
        wait_strb();
        n_vec++;
        if (minute_strb !== 1'b1) begin
            n_err++;
            $display("FAIL frame_start: minute_strb=%b required 1 within the minute budget", minute_strb);
            return;
        end
        n_vec++;
        if (stale !== exp_stale) begin
            n_err++;
            $display("FAIL frame_stale: got %b expected %b", stale, exp_stale);
        end
        n_vec++;
        if (second !== 6'd0) begin
            n_err++;
            $display("FAIL frame_second0: got %0d expected 0", second);
        end
        @(negedge clk);
        n_vec++;
        if (minute_strb !== 1'b0) begin
            n_err++;
            $display("FAIL strb_width: got %b expected 0 on second clk", minute_strb);
        end
        @(negedge clk);
        for (int s = 0; s < n_secs; s++) begin
            obs_len = 0;
            hole = 1'b0;
            for (int t = 0; t < TB_TPS; t++) begin
                if (s != 0 || t != 0) repeat (TB_CLKS) @(negedge clk);
                if (tx === 1'b1) begin
                    if (obs_len != t) hole = 1'b1;
                    obs_len++;
                end
                if (t == 50) begin
                    n_vec++;
                    if (second !== 6'(s)) begin
                        n_err++;
                        $display("FAIL second_idx: got %0d expected %0d", second, s);
                    end
                end
            end
            obs_arr[s] = hole ? -1 : obs_len;
            exp_len = exp_q.pop_front();
            n_vec++;
            if (hole || obs_len != int'(exp_len)) begin
                n_err++;
                $display("FAIL pulse_s%0d: got %0d ticks (gap=%b) expected %0d", s, obs_len, hole, exp_len);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset(input logic do_load, input tb_time_t tm);
        tb_time_t junk;
        int load_k, tx_hi, sec_bad, strb_early, rdy_bad;
        junk = rand_time();
        load_k = $urandom_range(10, 390);
        tx_hi = 0; sec_bad = 0; strb_early = 0; rdy_bad = 0;
        rst = 1'b1;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (tx !== 1'b0 || second !== 6'd59 || stale !== 1'b1 || minute_strb !== 1'b0 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_values: tx=%b second=%0d stale=%b strb=%b ready=%b expected 0 59 1 0 1",
                     tx, second, stale, minute_strb, load_ready);
        end
        for (int k = 1; k <= 400; k++) begin
            if (do_load && k == 2) begin
                drive_time(junk);
                load_valid = 1'b1;
            end else if (do_load && k == load_k) begin
                drive_time(tm);
                load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 400) begin
                if (tx !== 1'b0) tx_hi++;
                if (second !== 6'd59) sec_bad++;
                if (minute_strb !== 1'b0) strb_early++;
                if (load_ready !== ((k == 399) ? 1'b0 : 1'b1)) rdy_bad++;
            end
        end
        load_valid = 1'b0;
        n_vec++;
        if (tx_hi != 0) begin n_err++; $display("FAIL silent_tx: got %0d high clks expected 0", tx_hi); end
        n_vec++;
        if (sec_bad != 0) begin n_err++; $display("FAIL silent_second: got %0d clks off 59 expected 0", sec_bad); end
        n_vec++;
        if (strb_early != 0) begin n_err++; $display("FAIL strb_early: got %0d strobes expected 0", strb_early); end
        n_vec++;
        if (rdy_bad != 0) begin n_err++; $display("FAIL ready_silent: got %0d wrong clks expected 0", rdy_bad); end
        n_vec++;
        if (minute_strb !== 1'b1 || second !== 6'd0) begin
            n_err++;
            $display("FAIL first_strb: strb=%b second=%0d expected 1 0", minute_strb, second);
        end
    endtask

    task automatic test_load_frame(input tb_time_t a);
        int min_obs, hour_obs;
        run_frame(a, 1'b0, 60);
        min_obs = 0;
        hour_obs = 0;
        for (int i = 0; i < 7; i++) if (obs_arr[21 + i] == 20) min_obs |= (1 << i);
        for (int i = 0; i < 6; i++) if (obs_arr[29 + i] == 20) hour_obs |= (1 << i);
        n_vec++;
        if (min_obs != 'h37) begin n_err++; $display("FAIL minute_field: got %0h expected 37", min_obs); end
        n_vec++;
        if (hour_obs != 'h21) begin n_err++; $display("FAIL hour_field: got %0h expected 21", hour_obs); end
        n_vec++;
        if (obs_arr[28] != 20) begin n_err++; $display("FAIL p1_bit: got %0d ticks expected 20", obs_arr[28]); end
        n_vec++;
        if (obs_arr[35] != 10) begin n_err++; $display("FAIL p2_bit: got %0d ticks expected 10", obs_arr[35]); end
        n_vec++;
        if (obs_arr[17] != 20 || obs_arr[18] != 10) begin
            n_err++;
            $display("FAIL zone_bits: got %0d/%0d ticks expected 20/10", obs_arr[17], obs_arr[18]);
        end
        n_vec++;
        if (obs_arr[20] != 20 || obs_arr[59] != 0) begin
            n_err++;
            $display("FAIL start_marker: got %0d/%0d ticks expected 20/0", obs_arr[20], obs_arr[59]);
        end
    endtask

    task automatic test_reload(input tb_time_t a, input tb_time_t b);
        fork
            run_frame(a, 1'b1, 60);
            begin
                wait_strb();
                repeat (30 * TB_TPS * TB_CLKS + $urandom_range(0, 399)) @(negedge clk);
                drive_time(b);
                load_valid = 1'b1;
                @(negedge clk);
                load_valid = 1'b0;
            end
        join
    endtask

    task automatic test_back_to_back(input tb_time_t b, input tb_time_t c);
        fork
            run_frame(b, 1'b0, 60);
            begin
                @(negedge clk);
                drive_time(c);
                load_valid = 1'b1;
                #1;
                n_vec++;
                if (load_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL ready_transfer: got %b expected 0", load_ready);
                end
                @(negedge clk);
                n_vec++;
                if (load_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL ready_after: got %b expected 1", load_ready);
                end
                @(posedge clk);
                #1;
                load_valid = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid_pulse(input tb_time_t c);
        tb_time_t zero;
        logic exp_tx;
        zero = '{minute: 0, hour: 0, day: 0, week_day: 0, month: 0, year: 0, zone: 0};
        run_frame(c, 1'b0, 25);
        repeat (TB_CLKS * 6) @(negedge clk);
        exp_tx = (5 < model_pulse(c, 25)) ? 1'b1 : 1'b0;
        n_vec++;
        if (tx !== exp_tx) begin n_err++; $display("FAIL pulse_before_rst: got %b expected %b", tx, exp_tx); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b0 || second !== 6'd59 || stale !== 1'b1) begin
            n_err++;
            $display("FAIL rst_abort: tx=%b second=%0d stale=%b expected 0 59 1", tx, second, stale);
        end
        test_reset(1'b0, zero);
        run_frame(zero, 1'b1, 3);
    endtask

    initial begin
        tb_time_t a, b, c;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        load_valid = 1'b0;
        minute = '0; hour = '0; day = '0; week_day = '0; month = '0; year = '0; zone = '0;
        a = '{minute: 'h37, hour: 'h21, day: 'h14, week_day: 2, month: 'h05, year: 'h24, zone: 1};
        b = rand_time();
        c = rand_time();
        c.minute = (int'($urandom_range(0, 2)) * 2 + 1) * 16 + int'($urandom_range(0, 9));
        repeat (2) @(negedge clk);

        test_reset(1'b1, a);
        test_load_frame(a);
        test_reload(a, b);
        test_back_to_back(b, c);
        test_reset_mid_pulse(c);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
